// File: rtl/tile_fill_engine_if.sv
// Command and framebuffer-write bundle for tile_fill_engine.
// The engine takes the slave modport; whatever issues commands takes master.
interface tile_fill_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_col;
    logic [2:0]  cmd_row;
    logic [7:0]  cmd_color;
    logic [15:0] fb_wraddr;
    logic [7:0]  fb_data;
    logic        fb_wren;
    logic        busy;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_col, cmd_row, cmd_color,
        input  cmd_ready, fb_wraddr, fb_data, fb_wren, busy, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_col, cmd_row, cmd_color,
        output cmd_ready, fb_wraddr, fb_data, fb_wren, busy, cmd_err
    );
endinterface

// File: rtl/tile_fill_engine.sv
// Queues tile fill commands in a 4-deep FIFO and paints each tile into the framebuffer.
// Define TILE_FILL_BORDER_EN to paint the outer ring of every tile 8'hFF.
module tile_fill_engine #(
    parameter int TILE_PX  = 48,
    parameter int GRID_DIM = 5,
    parameter int FB_DIM   = 240
) (
    input logic          CLOCK_50,
    input logic          reset,
    tile_fill_engine_if.slave bus
);
    localparam int CW = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILE_PX - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL} state_t;

    state_t      state;
    logic [13:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        full, empty, accept, cmd_bad, push, pop;
    logic        err_q;

    logic [2:0]    cur_col, cur_row;
    logic [7:0]    cur_color;
    logic [15:0]   base_x, base_y;
    logic [CW-1:0] i, j;
    logic [15:0]   pix_x, pix_y, pix_addr;
    logic [7:0]    pix_data;
    logic          wren_q;
    logic [15:0]   addr_q;
    logic [7:0]    data_q;

    // Out-of-grid commands are still handshaken so the sender never stalls on them.
    always_comb begin
        full    = (count == 3'd4);
        empty   = (count == 3'd0);
        accept  = bus.cmd_valid && !full;
        cmd_bad = (32'(bus.cmd_col) >= GRID_DIM) || (32'(bus.cmd_row) >= GRID_DIM);
        push    = accept && !cmd_bad;
        pop     = (state == IDLE) && !empty;
    end

    always_comb begin
        pix_x    = base_x + 16'(i);
        pix_y    = base_y + 16'(j);
        pix_addr = pix_x * 16'(FB_DIM) + pix_y;
`ifdef TILE_FILL_BORDER_EN
        pix_data = (i == '0 || j == '0 || i == LAST || j == LAST) ? 8'hFF : cur_color;
`else
        pix_data = cur_color;
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && cmd_bad;
            if (push) begin
                fifo_mem[wr_ptr] <= {bus.cmd_col, bus.cmd_row, bus.cmd_color};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // j runs fastest; the last pixel's write returns straight to IDLE.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            cur_col   <= '0;
            cur_row   <= '0;
            cur_color <= '0;
            base_x    <= '0;
            base_y    <= '0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            wren_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {cur_col, cur_row, cur_color} <= fifo_mem[rd_ptr];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    base_x <= 16'(cur_col) * 16'(TILE_PX);
                    base_y <= 16'(cur_row) * 16'(TILE_PX);
                    i      <= '0;
                    j      <= '0;
                    state  <= FILL;
                end
                FILL: begin
                    wren_q <= 1'b1;
                    addr_q <= pix_addr;
                    data_q <= pix_data;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST)
                            state <= IDLE;
                        else
                            i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state != IDLE);
    assign bus.cmd_err   = err_q;
    assign bus.fb_wren   = wren_q;
    assign bus.fb_wraddr = addr_q;
    assign bus.fb_data   = data_q;
endmodule

// File: tb/tb_tile_fill_engine.sv
// Directed self-checking bench for tile_fill_engine (48px tiles, 5x5 grid, 240px framebuffer).
// Border-pixel expectations follow TILE_FILL_BORDER_EN when the build defines it.
module tb_tile_fill_engine;
    localparam int TILE_PX     = 48;
    localparam int FB_DIM      = 240;
    localparam int TILE_WRITES = TILE_PX * TILE_PX;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    tile_fill_engine_if bus();

    tile_fill_engine #(.TILE_PX(48), .GRID_DIM(5), .FB_DIM(240)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus.slave)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int unsigned cycle = 0;
    always @(posedge CLOCK_50) cycle <= cycle + 1;

    logic [15:0] addr_q [$];
    logic [7:0]  data_q [$];
    int unsigned when_q [$];

    // Every write seen on the bus is logged with the cycle it appeared in.
    always @(negedge CLOCK_50) begin
        if (bus.fb_wren === 1'b1) begin
            addr_q.push_back(bus.fb_wraddr);
            data_q.push_back(bus.fb_data);
            when_q.push_back(cycle);
        end
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int i, input int j, input logic [7:0] color);
`ifdef TILE_FILL_BORDER_EN
        if (i == 0 || j == 0 || i == TILE_PX - 1 || j == TILE_PX - 1)
            return 8'hFF;
`endif
        return color;
    endfunction

    task automatic wait_neg();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic drive_cmd(input logic [2:0] col, input logic [2:0] row, input logic [7:0] color);
        bus.cmd_valid = 1'b1;
        bus.cmd_col   = col;
        bus.cmd_row   = row;
        bus.cmd_color = color;
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int n = 0;
        while (addr_q.size() < target && n < budget) begin
            wait_neg();
            n++;
        end
        if (addr_q.size() < target)
            chk(tag, addr_q.size(), target);
    endtask

    task automatic check_tile(input int base, input int col, input int row,
                              input logic [7:0] color, input string tag);
        int bad = 0;
        for (int i = 0; i < TILE_PX; i++) begin
            for (int j = 0; j < TILE_PX; j++) begin
                int idx = base + i * TILE_PX + j;
                int ea  = (col * TILE_PX + i) * FB_DIM + row * TILE_PX + j;
                if (idx >= addr_q.size())
                    bad++;
                else if (addr_q[idx] !== 16'(ea) || data_q[idx] !== exp_data(i, j, color))
                    bad++;
            end
        end
        chk(tag, bad, 0);
    endtask

    logic [2:0] bp_col   [6] = '{3'd0, 3'd4, 3'd2, 3'd3, 3'd1, 3'd4};
    logic [2:0] bp_row   [6] = '{3'd0, 3'd4, 3'd3, 3'd1, 3'd4, 3'd0};
    logic [7:0] bp_color [6] = '{8'h03, 8'h1F, 8'h55, 8'hAA, 8'h92, 8'h6D};

    initial begin
        int n0;
        int idx;
        int guard;
        logic saw_low;
        logic ready_now;

        // Reset with a legal command presented: it must be ignored.
        drive_cmd(3'd1, 3'd1, 8'h77);
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        wait_neg();
        chk("rst_wren",  32'(bus.fb_wren),   0);
        chk("rst_addr",  32'(bus.fb_wraddr), 0);
        chk("rst_data",  32'(bus.fb_data),   0);
        chk("rst_err",   32'(bus.cmd_err),   0);
        chk("rst_busy",  32'(bus.busy),      0);
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (5) wait_neg();
        chk("rst_cmd_ignored_busy",   32'(bus.busy), 0);
        chk("rst_cmd_ignored_writes", addr_q.size(), 0);

        // Single tile col=1 row=2: first write visible after edge k+3.
        drive_cmd(3'd1, 3'd2, 8'hE0);
        @(posedge CLOCK_50);
        wait_neg();
        bus.cmd_valid = 1'b0;
        chk("lat_k1_wren", 32'(bus.fb_wren), 0);
        chk("lat_k1_busy", 32'(bus.busy), 1);
        wait_neg();
        chk("lat_k2_wren", 32'(bus.fb_wren), 0);
        wait_neg();
        chk("lat_k3_wren", 32'(bus.fb_wren), 0);
        wait_neg();
        chk("lat_k4_wren", 32'(bus.fb_wren), 1);
        chk("first_addr",  32'(bus.fb_wraddr), 11616);
        chk("first_data",  32'(bus.fb_data), 32'(exp_data(0, 0, 8'hE0)));
        wait_writes(TILE_WRITES, 2400, "single_timeout");
        repeat (5) wait_neg();
        chk("single_count", addr_q.size(), TILE_WRITES);
        chk("single_last_addr", 32'(addr_q[TILE_WRITES - 1]), 22943);
        check_tile(0, 1, 2, 8'hE0, "single_tile_contents");
        chk("single_busy_low", 32'(bus.busy), 0);
        chk("hold_addr", 32'(bus.fb_wraddr), 22943);
        chk("hold_data", 32'(bus.fb_data), 32'(exp_data(47, 47, 8'hE0)));

        // Out-of-grid commands: one-cycle error pulse, nothing queued.
        n0 = addr_q.size();
        drive_cmd(3'd5, 3'd0, 8'h3C);
        @(posedge CLOCK_50);
        wait_neg();
        bus.cmd_valid = 1'b0;
        chk("bad_col_err",      32'(bus.cmd_err), 1);
        wait_neg();
        chk("bad_col_err_fall", 32'(bus.cmd_err), 0);
        chk("bad_col_busy",     32'(bus.busy), 0);
        drive_cmd(3'd0, 3'd6, 8'h3C);
        @(posedge CLOCK_50);
        wait_neg();
        bus.cmd_valid = 1'b0;
        chk("bad_row_err", 32'(bus.cmd_err), 1);
        repeat (10) wait_neg();
        chk("bad_no_writes", addr_q.size(), n0);
        chk("bad_busy_low",  32'(bus.busy), 0);

        // Back-pressure: six commands with cmd_valid held high.
        n0 = addr_q.size();
        idx = 0;
        guard = 0;
        saw_low = 1'b0;
        while (idx < 6 && guard < 8000) begin
            drive_cmd(bp_col[idx], bp_row[idx], bp_color[idx]);
            ready_now = bus.cmd_ready;
            if (!ready_now)
                saw_low = 1'b1;
            @(posedge CLOCK_50);
            wait_neg();
            if (ready_now)
                idx++;
            guard++;
        end
        bus.cmd_valid = 1'b0;
        chk("bp_all_accepted", idx, 6);
        chk("bp_ready_dropped", 32'(saw_low), 1);
        wait_writes(n0 + 6 * TILE_WRITES, 16000, "bp_timeout");
        repeat (5) wait_neg();
        chk("bp_count", addr_q.size(), n0 + 6 * TILE_WRITES);
        for (int t = 0; t < 6; t++)
            check_tile(n0 + t * TILE_WRITES, int'(bp_col[t]), int'(bp_row[t]), bp_color[t],
                       $sformatf("bp_tile%0d", t));
        chk("bp_gap_cycles", when_q[n0 + TILE_WRITES] - when_q[n0 + TILE_WRITES - 1], 3);

        // Reset during write #100 of a tile, with a second command still queued.
        n0 = addr_q.size();
        drive_cmd(3'd2, 3'd2, 8'h44);
        @(posedge CLOCK_50);
        wait_neg();
        drive_cmd(3'd3, 3'd3, 8'h11);
        @(posedge CLOCK_50);
        wait_neg();
        bus.cmd_valid = 1'b0;
        wait_writes(n0 + 100, 400, "midfill_timeout");
        chk("midfill_at_100", addr_q.size(), n0 + 100);
        reset = 1'b1;
        @(posedge CLOCK_50);
        wait_neg();
        chk("midfill_wren",  32'(bus.fb_wren), 0);
        chk("midfill_busy",  32'(bus.busy), 0);
        chk("midfill_ready", 32'(bus.cmd_ready), 1);
        chk("midfill_addr",  32'(bus.fb_wraddr), 0);
        reset = 1'b0;
        repeat (200) wait_neg();
        chk("midfill_no_resume", addr_q.size(), n0 + 100);
        chk("midfill_idle",      32'(bus.busy), 0);

        // Tile (0,0): corner and edge pixels versus an interior pixel.
        n0 = addr_q.size();
        drive_cmd(3'd0, 3'd0, 8'h1C);
        @(posedge CLOCK_50);
        wait_neg();
        bus.cmd_valid = 1'b0;
        wait_writes(n0 + TILE_WRITES, 2400, "border_timeout");
        repeat (5) wait_neg();
        chk("border_count",    addr_q.size(), n0 + TILE_WRITES);
        chk("border_a0_addr",  32'(addr_q[n0]), 0);
        chk("border_a0_data",  32'(data_q[n0]), 32'(exp_data(0, 0, 8'h1C)));
        chk("border_a241_addr", 32'(addr_q[n0 + 49]), 241);
        chk("border_a241_data", 32'(data_q[n0 + 49]), 32'h1C);
        chk("border_a47_addr", 32'(addr_q[n0 + 47]), 47);
        chk("border_a47_data", 32'(data_q[n0 + 47]), 32'(exp_data(0, 47, 8'h1C)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/tile_fill_engine.md
TILE_FILL_ENGINE -- requirements
Module: tile_fill_engine

Interface
REQ-001 SHALL have parameter TILE_PX, default 48, meaning tile edge length in framebuffer pixels.
REQ-002 SHALL have parameter GRID_DIM, default 5, meaning number of tiles per row and per column.
REQ-003 SHALL have parameter FB_DIM, default 240, meaning framebuffer edge length in pixels.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the sole clock, rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a tile command is presented.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the command FIFO can accept a command.
REQ-008 SHALL have port cmd_col, input, 3 bits: tile column, selects the x pixel range.
REQ-009 SHALL have port cmd_row, input, 3 bits: tile row, selects the y pixel range.
REQ-010 SHALL have port cmd_color, input, 8 bits: RRRGGGBB fill colour.
REQ-011 SHALL have port fb_wraddr, output, 16 bits: framebuffer write address.
REQ-012 SHALL have port fb_data, output, 8 bits: framebuffer write data.
REQ-013 SHALL have port fb_wren, output, 1 bit: framebuffer write strobe.
REQ-014 SHALL have port busy, output, 1 bit: the FIFO is non-empty or the engine is not IDLE.
REQ-015 SHALL have port cmd_err, output, 1 bit: one-cycle pulse flagging a rejected command.

Function
REQ-016 SHALL accept a command on a rising edge where cmd_valid && cmd_ready.
REQ-017 SHALL hold commands in a 4-entry FIFO; cmd_ready = !full.
REQ-018 SHALL allow a push and a pop in the same cycle; the occupancy count is then unchanged.
REQ-019 SHALL treat an accepted command with cmd_col >= GRID_DIM or cmd_row >= GRID_DIM as invalid: not enqueued, and cmd_err high for exactly the one cycle after the accepting edge.
REQ-020 SHALL implement three states: IDLE, LOAD and FILL.
REQ-021 In IDLE, when the FIFO is non-empty, SHALL pop the head entry and go to LOAD.
REQ-022 In LOAD, SHALL latch base_x = col*TILE_PX and base_y = row*TILE_PX, clear the counters i and j, and go to FILL.
REQ-023 In FILL, SHALL issue one write per cycle at x = base_x+i, y = base_y+j, with fb_wraddr = x*FB_DIM + y (16-bit, no truncation for legal commands).
REQ-024 SHALL step j fastest; when j reaches TILE_PX-1, j wraps to 0 and i increments.
REQ-025 After the write at i = j = TILE_PX-1, SHALL return to IDLE; one tile produces exactly TILE_PX*TILE_PX writes.
REQ-026 SHALL register fb_wren, fb_wraddr and fb_data; fb_wren is high only for FILL writes.
REQ-027 SHALL hold fb_wraddr and fb_data at their last values while fb_wren is low.
REQ-028 SHALL, when IDLE with an empty FIFO, assert the first fb_wren of a command accepted at edge k in the cycle after edge k+3.
REQ-029 SHALL, with further commands queued, place exactly 2 non-write cycles (IDLE, LOAD) between consecutive tiles.
REQ-030 SHALL reference no clocks other than CLOCK_50.

Reset
REQ-031 While reset is high at an edge, SHALL empty the FIFO, enter IDLE and clear i and j.
REQ-032 While reset is high at an edge, SHALL drive fb_wren=0, fb_wraddr=0, fb_data=0, cmd_err=0, busy=0 and cmd_ready=1.
REQ-033 On reset asserted mid-FILL, SHALL emit no further writes of the aborted tile, and the aborted tile SHALL NOT resume after reset.
REQ-034 SHALL ignore cmd_valid in any cycle where reset is high.

Configuration
REQ-035 SHALL honour the macro TILE_FILL_BORDER_EN.
REQ-036 With TILE_FILL_BORDER_EN defined, pixels with i or j equal to 0 or TILE_PX-1 SHALL be written 8'hFF; all other pixels SHALL be written cmd_color.
REQ-037 With TILE_FILL_BORDER_EN undefined, every pixel SHALL be written cmd_color, and no border logic SHALL be synthesised.

Verification
REQ-038 Bench SHALL cover single tile, defaults: col=1, row=2, color=0xE0 -> 2304 writes; first addr 11616, last addr 22943; data 0xE0; busy falls after the last write.
REQ-039 Bench SHALL cover invalid command: col=5, row=0 -> cmd_err pulses once; no fb_wren; FIFO unchanged.
REQ-040 Bench SHALL cover back-pressure: 6 commands with cmd_valid held high from IDLE -> cmd_ready drops low; all 6 tiles are written in order with no loss or duplication.
REQ-041 Bench SHALL cover reset mid-fill: reset pulsed during write #100 -> fb_wren=0 after the edge; the FIFO is empty; no further writes until a new command.
REQ-042 Bench SHALL cover TILE_FILL_BORDER_EN defined: col=0, row=0, color=0x1C -> addr 0 is written 0xFF; addr 241 (i=1, j=1) is written 0x1C; addr 47 is written 0xFF.
